// File: rtl/filtered_ram_fill_sequencer_if.sv
// Handshake/bus bundle between a fill sequencer and its host RAM, FIR and bank.
// Latency: none (wires only).
// Backpressure: hs_stall from the host RAM holds read issue; no other backpressure.
interface filtered_ram_fill_sequencer_if #(
  parameter int S_WIDTH    = 9,
  parameter int FILT_WIDTH = 16
);
  logic                  fill_kick;
  logic                  hs_stall;
  logic [S_WIDTH-1:0]    hs_s_val;
  logic                  hs_rd_en;
  logic [FILT_WIDTH-1:0] fir_val;   // signed sample, carried as raw bits
  logic                  wr_en;
  logic [S_WIDTH-1:0]    wr_addr;
  logic [FILT_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  fill_done;

  // Sequencer side
  modport master (
    input  fill_kick, hs_stall, fir_val,
    output hs_s_val, hs_rd_en, wr_en, wr_addr, wr_data, busy, fill_done
  );

  // Swap controller / host RAM / FIR / bank side
  modport slave (
    output fill_kick, hs_stall, fir_val,
    input  hs_s_val, hs_rd_en, wr_en, wr_addr, wr_data, busy, fill_done
  );
endinterface

// File: rtl/filtered_ram_fill_sequencer.sv
// Fills one filtered RAM bank: reads every sample of an angle, writes each FIR result at its s address.
// Latency: first write PIPE_LATENCY cycles after first read; fill_done LINE_SIZE+PIPE_LATENCY+1 cycles after kick (no stalls).
// Backpressure: hs_stall holds the issue counter and injects bubbles into the tracking pipeline.
module filtered_ram_fill_sequencer #(
  parameter int LINE_SIZE    = 256,
  parameter int S_WIDTH      = 9,
  parameter int FILT_WIDTH   = 16,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  filtered_ram_fill_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [S_WIDTH-1:0] LAST_ADDR = S_WIDTH'(LINE_SIZE - 1);
  localparam logic [S_WIDTH-1:0] ONE       = S_WIDTH'(1);

  state_t                               r_state;
  logic [S_WIDTH-1:0]                   r_iss_cnt;
  logic [S_WIDTH-1:0]                   r_wr_cnt;
  logic                                 r_busy;
  logic                                 r_fill_done;
  logic [PIPE_LATENCY-1:0]              r_pipe_vld;
  logic [PIPE_LATENCY-1:0][S_WIDTH-1:0] r_pipe_addr;

  logic               w_rd_en;
  logic               w_wr_en;
  logic [S_WIDTH-1:0] w_tail_addr;

  // Outputs are forced low while reset_n is asserted so nothing in flight
  // can reach the bank in the reset cycle itself.
  assign w_rd_en     = reset_n && (r_state == ISSUE) && !bus.hs_stall;
  assign w_wr_en     = reset_n && r_pipe_vld[PIPE_LATENCY-1];
  assign w_tail_addr = r_pipe_addr[PIPE_LATENCY-1];

  assign bus.hs_rd_en  = w_rd_en;
  assign bus.hs_s_val  = w_rd_en ? r_iss_cnt : '0;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_addr   = w_wr_en ? w_tail_addr : '0;
  assign bus.wr_data   = w_wr_en ? bus.fir_val : '0;
  assign bus.busy      = reset_n && r_busy;
  assign bus.fill_done = reset_n && r_fill_done;

  // Fill control: issue counter, write counter and state with registered busy/fill_done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_iss_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_busy      <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + ONE;
      end
      case (r_state)
        IDLE, DONE: begin
          if (bus.fill_kick) begin
            r_state     <= ISSUE;
            r_iss_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_busy      <= 1'b1;
            r_fill_done <= 1'b0;
          end
        end
        ISSUE: begin
          if (w_rd_en) begin
            // Counter is allowed to reach LINE_SIZE; it never wraps.
            r_iss_cnt <= r_iss_cnt + ONE;
            if (r_iss_cnt == LAST_ADDR) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last write is the one taking the counter to LINE_SIZE.
          if (w_wr_en && (r_wr_cnt == LAST_ADDR)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_fill_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tracking pipeline: one {valid, address} slot per cycle of host-RAM/FIR latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pipe_vld  <= '0;
      r_pipe_addr <= '0;
    end else begin
      r_pipe_vld[0]  <= w_rd_en;
      r_pipe_addr[0] <= r_iss_cnt;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

endmodule

// File: doc/filtered_ram_fill_sequencer.md
Name: filtered_ram_fill_sequencer

Overview:
Sequences the fill of one filtered RAM bank for a single projection angle. On a fill kick it reads every projection sample from the host RAM and tracks each read through the host-RAM/FIR pipeline. It writes each filtered sample into the bank at the matching s address, then reports fill done. One instance serves each bank of the double-buffered filtered RAM; the swap controller drives fill_kick and consumes fill_done.

Parameters:
LINE_SIZE, 256, projection samples per angle (bank depth); ≥ 2
S_WIDTH, 9, width of s address; ≥ clog2(LINE_SIZE+1)
FILT_WIDTH, 16, filtered sample width
PIPE_LATENCY, 4, cycles from hs_rd_en asserted to the matching fir_val presented; ≥ 1

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
fill_kick  in  1  one-cycle pulse: start filling for the current angle
hs_stall  in  1  host RAM unavailable; no read issued this cycle
hs_s_val  out  S_WIDTH  host RAM read address
hs_rd_en  out  1  host RAM read strobe
fir_val  in  FILT_WIDTH  signed filtered sample, valid PIPE_LATENCY cycles after its read
wr_en  out  1  bank write enable
wr_addr  out  S_WIDTH  bank write address
wr_data  out  FILT_WIDTH  bank write data (= fir_val)
busy  out  1  fill in progress
fill_done  out  1  bank full and valid; level signal

Behaviour:
- Reset values: all outputs 0. State IDLE. Counters 0. Pipeline valid bits cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on fill_kick go to ISSUE, clear the issue and write counters, and clear fill_done.
- DONE: behaves as IDLE, but fill_done = 1. fill_kick in DONE restarts exactly as from IDLE.
- ISSUE: each cycle with hs_stall = 0, assert hs_rd_en and drive hs_s_val = issue counter, then increment the counter. With hs_stall = 1, hs_rd_en = 0 and the counter holds. After the read with address LINE_SIZE-1 is issued, go to DRAIN.
- hs_rd_en and hs_s_val are combinational from state, counter and hs_stall. There is no bubble between the kick cycle+1 and the first read.
- Tracking pipeline: a shift register of depth PIPE_LATENCY carries a {valid, address} pair. Stall cycles insert valid = 0 bubbles.
- At the pipeline tail with valid = 1: wr_en = 1, wr_addr = tail address, wr_data = fir_val, all in the same cycle (combinational), and the write counter increments.
- DRAIN: no reads are issued. When the write counter reaches LINE_SIZE, go to DONE; fill_done rises in the cycle after the last write.
- busy = 1 in ISSUE and DRAIN.
- Fill duration without stalls: first write PIPE_LATENCY cycles after the first read. fill_done rises LINE_SIZE + PIPE_LATENCY + 1 cycles after the kick cycle.
- fill_kick while busy: ignored. Counters and pipeline are undisturbed.
- hs_stall in IDLE, DRAIN or DONE: no effect.
- The s counter never wraps. Issue stops at LINE_SIZE-1, and the counter width holds LINE_SIZE.
- Reset mid-fill: returns to IDLE immediately and flushes the pipeline valid bits. No wr_en occurs after the reset cycle, even for reads already in flight.
- Writes occur strictly in ascending address order, exactly once per address per fill.

Test Plan:
1. LINE_SIZE=8, PIPE_LATENCY=3, no stall. Kick at cycle 0 → hs_rd_en cycles 1–8 with s = 0..7. wr_en cycles 4–11 with addr 0..7 and wr_data = fir_val. fill_done = 1 from cycle 12.
2. Same, but hs_stall = 1 in cycles 3–4 → reads s = 0,1 then 2..7 in cycles 5–10. Writes skip cycles 6–7 with addresses still 0..7 in order. fill_done from cycle 14.
3. Second fill_kick at cycle 5 of an active fill → ignored; the sequence is identical to scenario 1.
4. reset_n = 0 at cycle 6 of a fill → from cycle 6 on, all outputs 0 and no wr_en. A kick at cycle 8 starts a clean fill with addresses 0..7.
5. fill_kick while in DONE → fill_done drops in the next cycle and a full new fill runs. Back-to-back fills give 8 writes each, with no lost or duplicate address.
6. PIPE_LATENCY=1, LINE_SIZE=2 boundary → reads cycles 1–2, writes cycles 2–3 with addr 0,1, fill_done from cycle 4.
